des_key_sched_iter: RTL and testbench

- Iterative, handshaked DES round-key generator. Replaces the fully unrolled 16×PC2 combinational schedule with one C/D register pair and one PC2 instance.
- Accepts a 64-bit key. Emits ROUNDS 48-bit subkeys one per accepted beat, in encrypt order (K1..Kn) or decrypt order (Kn..K1).
- Uses true 28-bit circular rotations, left for encrypt and right for decrypt.
- Sits between the key register and the round datapath of the iterative DES core.

---
 rtl/des_key_sched_iter_if.sv | 27 ++
 rtl/des_key_sched_iter.sv | 191 +++++++++++++++++++
 tb/tb_des_key_sched_iter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/des_key_sched_iter_if.sv
// Key-in / subkey-out handshake bundle for the iterative DES key schedule.
// The key register drives the master side; the schedule implements the slave side.
interface des_key_sched_iter_if #(
  parameter int IDX_W = 4
);
  logic [63:0]      key;
  logic             decrypt;
  logic             key_valid;
  logic             key_ready;
  logic [47:0]      rk;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_last;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             weak_key;

  modport master (
    output key, decrypt, key_valid, rk_ready,
    input  key_ready, rk, rk_idx, rk_last, rk_valid, busy, weak_key
  );

  modport slave (
    input  key, decrypt, key_valid, rk_ready,
    output key_ready, rk, rk_idx, rk_last, rk_valid, busy, weak_key
  );
endinterface

// File: rtl/des_key_sched_iter.sv
// Iterative DES round-key generator: one C/D register pair and one PC2, one subkey per beat.
// Optional weak-key flag is built only when DES_KS_WEAK_KEY_DET_EN is defined.
module des_key_sched_iter #(
  parameter int          ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h8103,
  parameter int          IDX_W      = 4
) (
  input logic                 clk,
  input logic                 rst,
  des_key_sched_iter_if.slave ks
);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Table entries are 1-based from the MSB, as in the DES standard.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

  function automatic logic [4:0] shift_of(input int i);
    if (i < 0 || i >= ROUNDS) begin
      return 5'd1;
    end
    return SHIFT_MASK[i[3:0]] ? 5'd1 : 5'd2;
  endfunction

  function automatic int total_shift();
    int t;
    t = 0;
    for (int i = 0; i < ROUNDS; i++) begin
      t += SHIFT_MASK[i[3:0]] ? 1 : 2;
    end
    return t;
  endfunction

  // Decrypt starts from the state after all rotations, reached from PC1 by a left rotate of T mod 28.
  localparam int               TOTAL_SHIFT = total_shift();
  localparam logic [4:0]       DEC_FIRST   = 5'(TOTAL_SHIFT % 28);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [27:0]      c_q, d_q;
  logic [IDX_W-1:0] cnt_q;
  logic             dec_q;
  logic [47:0]      rk_q;
  logic [IDX_W-1:0] rk_idx_q;
  logic             rk_last_q;
  logic             rk_valid_q;
  logic             accept;
  logic             beat;
  logic [55:0]      key_pc1;
  logic [4:0]       first_rot;

  assign ks.key_ready = (state == IDLE) && !rst;
  assign accept       = ks.key_valid && ks.key_ready;
  assign beat         = rk_valid_q && ks.rk_ready;
  assign key_pc1      = pc1(ks.key);
  assign first_rot    = ks.decrypt ? DEC_FIRST : shift_of(0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = GEN;
      GEN:     if (beat && rk_last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // GEN alternates refill (rk_valid low, load PC2 of C/D) and beat (rotate C/D to the next round).
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
      rk_valid_q <= 1'b0;
    end else if (accept) begin
      c_q   <= rotl28(key_pc1[55:28], first_rot);
      d_q   <= rotl28(key_pc1[27:0], first_rot);
      dec_q <= ks.decrypt;
      cnt_q <= ks.decrypt ? LAST_IDX : '0;
    end else if (state == GEN) begin
      if (!rk_valid_q) begin
        rk_q       <= pc2({c_q, d_q});
        rk_idx_q   <= cnt_q;
        rk_last_q  <= dec_q ? (cnt_q == '0) : (cnt_q == LAST_IDX);
        rk_valid_q <= 1'b1;
      end else if (ks.rk_ready) begin
        rk_valid_q <= 1'b0;
        if (!rk_last_q) begin
          if (dec_q) begin
            c_q   <= rotr28(c_q, shift_of(int'(cnt_q)));
            d_q   <= rotr28(d_q, shift_of(int'(cnt_q)));
            cnt_q <= cnt_q - 1'b1;
          end else begin
            c_q   <= rotl28(c_q, shift_of(int'(cnt_q) + 1));
            d_q   <= rotl28(d_q, shift_of(int'(cnt_q) + 1));
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign ks.rk       = rk_q;
  assign ks.rk_idx   = rk_idx_q;
  assign ks.rk_last  = rk_last_q;
  assign ks.rk_valid = rk_valid_q;
  assign ks.busy     = (state == GEN);

`ifdef DES_KS_WEAK_KEY_DET_EN
  // Weak keys leave C and D uniform, so every round key comes out identical.
  logic weak_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      weak_q <= 1'b0;
    end else if (accept) begin
      weak_q <= ((key_pc1[55:28] == '0) || (key_pc1[55:28] == '1)) &&
                ((key_pc1[27:0] == '0) || (key_pc1[27:0] == '1));
    end
  end

  assign ks.weak_key = weak_q;
`else
  assign ks.weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Directed, table-driven bench for des_key_sched_iter using the textbook DES key 133457799BBCDFF1.
// Rows cover encrypt/decrypt order, backpressure, busy-time keys, chained keys, reset and weak keys.
module tb_des_key_sched_iter;

  localparam int ROUNDS = 16;
  localparam int IDX_W  = 4;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_W1 = 64'h0101010101010101;
  localparam logic [63:0] KEY_FE = 64'hFEFEFEFEFEFEFEFE;

  localparam logic [47:0] REF_A [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          stall_at;
    int          stall_len;
    int          busy_at;
    int          reset_at;
    bit          chain;
    logic        exp_weak;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs [8];

  always #5 clk = ~clk;

  des_key_sched_iter_if #(.IDX_W(IDX_W)) ks_bus ();

  des_key_sched_iter #(
    .ROUNDS    (ROUNDS),
    .SHIFT_MASK(16'h8103),
    .IDX_W     (IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ks (ks_bus)
  );

  function automatic logic [47:0] exp_rk(input logic [63:0] k, input int idx);
    if (k == KEY_A) return REF_A[idx];
    if (k == KEY_FE) return 48'hFFFFFFFFFFFF;
    return 48'h0;
  endfunction

  function automatic logic exp_weak_of(input vec_t v);
`ifdef DES_KS_WEAK_KEY_DET_EN
    return v.exp_weak;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts at a falling edge; returns at a falling edge (or just after one when reset was exercised).
  task automatic applyStimulus(input int n);
    vec_t v;
    int   waited;
    int   exp_idx;
    v = vecs[n];
    ks_bus.key       = v.key;
    ks_bus.decrypt   = v.dec;
    ks_bus.key_valid = 1'b1;
    waited = 0;
    while (ks_bus.key_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      checkOutput($sformatf("row%0d accept_timeout", n), 64'(waited), 64'd0);
      ks_bus.key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ks_bus.key_valid = 1'b0;
    ks_bus.key       = ~v.key;
    ks_bus.decrypt   = ~v.dec;
    checkOutput($sformatf("row%0d lat1_rk_valid", n), 64'(ks_bus.rk_valid), 64'd0);
    checkOutput($sformatf("row%0d busy", n), 64'(ks_bus.busy), 64'd1);
    checkOutput($sformatf("row%0d key_ready_busy", n), 64'(ks_bus.key_ready), 64'd0);
    checkOutput($sformatf("row%0d weak_key", n), 64'(ks_bus.weak_key), 64'(exp_weak_of(v)));

    for (int r = 0; r < ROUNDS; r++) begin
      exp_idx = v.dec ? ROUNDS - 1 - r : r;
      waited = 0;
      while (ks_bus.rk_valid !== 1'b1 && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      if (ks_bus.rk_valid !== 1'b1) begin
        checkOutput($sformatf("row%0d idx%0d valid_timeout", n, exp_idx), 64'(ks_bus.rk_valid), 64'd1);
        return;
      end
      if (r == 0) checkOutput($sformatf("row%0d first_latency", n), 64'(waited), 64'd1);
      checkOutput($sformatf("row%0d idx%0d rk", n, exp_idx), 64'(ks_bus.rk), 64'(exp_rk(v.key, exp_idx)));
      checkOutput($sformatf("row%0d idx%0d rk_idx", n, exp_idx), 64'(ks_bus.rk_idx), 64'(exp_idx));
      checkOutput($sformatf("row%0d idx%0d rk_last", n, exp_idx), 64'(ks_bus.rk_last), 64'(r == ROUNDS - 1));

      if (exp_idx == v.reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("row%0d rst rk_valid", n), 64'(ks_bus.rk_valid), 64'd0);
        checkOutput($sformatf("row%0d rst busy", n), 64'(ks_bus.busy), 64'd0);
        checkOutput($sformatf("row%0d rst rk", n), 64'(ks_bus.rk), 64'd0);
        checkOutput($sformatf("row%0d rst rk_idx", n), 64'(ks_bus.rk_idx), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput($sformatf("row%0d rst key_ready", n), 64'(ks_bus.key_ready), 64'd1);
        return;
      end

      if (exp_idx == v.stall_at) begin
        ks_bus.rk_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          @(negedge clk);
          checkOutput($sformatf("row%0d stall%0d rk_valid", n, s), 64'(ks_bus.rk_valid), 64'd1);
          checkOutput($sformatf("row%0d stall%0d rk", n, s), 64'(ks_bus.rk), 64'(exp_rk(v.key, exp_idx)));
          checkOutput($sformatf("row%0d stall%0d rk_idx", n, s), 64'(ks_bus.rk_idx), 64'(exp_idx));
        end
        ks_bus.rk_ready = 1'b1;
      end

      if (exp_idx == v.busy_at) begin
        ks_bus.key       = 64'hFFFFFFFFFFFFFFFF;
        ks_bus.key_valid = 1'b1;
        checkOutput($sformatf("row%0d busy_key key_ready", n), 64'(ks_bus.key_ready), 64'd0);
      end

      if (r == ROUNDS - 1 && v.chain) begin
        ks_bus.key       = vecs[n+1].key;
        ks_bus.decrypt   = vecs[n+1].dec;
        ks_bus.key_valid = 1'b1;
      end

      @(negedge clk);
      if (exp_idx == v.busy_at) ks_bus.key_valid = 1'b0;

      if (r == ROUNDS - 1) begin
        checkOutput($sformatf("row%0d done rk_valid", n), 64'(ks_bus.rk_valid), 64'd0);
        checkOutput($sformatf("row%0d done key_ready", n), 64'(ks_bus.key_ready), 64'd1);
        checkOutput($sformatf("row%0d done busy", n), 64'(ks_bus.busy), 64'd0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ks_bus.key       = '0;
    ks_bus.decrypt   = 1'b0;
    ks_bus.key_valid = 1'b0;
    ks_bus.rk_ready  = 1'b1;

    vecs[0] = '{KEY_A,      1'b0, -1, 0, -1, -1, 1'b0, 1'b0};
    vecs[1] = '{KEY_A,      1'b1, -1, 0, -1, -1, 1'b0, 1'b0};
    vecs[2] = '{KEY_A,      1'b0,  3, 5,  7, -1, 1'b1, 1'b0};
    vecs[3] = '{KEY_A,      1'b1, 12, 2, -1, -1, 1'b0, 1'b0};
    vecs[4] = '{KEY_A,      1'b0, -1, 0, -1,  9, 1'b0, 1'b0};
    vecs[5] = '{64'h0,      1'b0, -1, 0, -1, -1, 1'b0, 1'b1};
    vecs[6] = '{KEY_W1,     1'b1, -1, 0, -1, -1, 1'b0, 1'b1};
    vecs[7] = '{KEY_FE,     1'b0,  0, 3, -1, -1, 1'b0, 1'b1};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset key_ready_in_rst", 64'(ks_bus.key_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset key_ready", 64'(ks_bus.key_ready), 64'd1);
    checkOutput("reset rk_valid", 64'(ks_bus.rk_valid), 64'd0);
    checkOutput("reset rk", 64'(ks_bus.rk), 64'd0);
    checkOutput("reset rk_idx", 64'(ks_bus.rk_idx), 64'd0);
    checkOutput("reset rk_last", 64'(ks_bus.rk_last), 64'd0);
    checkOutput("reset busy", 64'(ks_bus.busy), 64'd0);
    checkOutput("reset weak_key", 64'(ks_bus.weak_key), 64'd0);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
